// File: rtl/idct_dot_acc_if.sv
// Stream interface between the IDCT multiplier wrapper, the dot-product
// accumulator and its downstream consumer.
//   P / p_valid / p_ready       : signed product stream into the accumulator
//   d_out / d_valid / d_ready   : rounded, saturated term stream out of it
// The master modport is the environment (product source plus term sink);
// the slave modport is the accumulator.
interface idct_dot_acc_if #(
  parameter int unsigned P_BITWIDTH   = 32,
  parameter int unsigned OUT_BITWIDTH = 16
);
  logic signed [P_BITWIDTH-1:0]   P;
  logic                           p_valid;
  logic                           p_ready;
  logic signed [OUT_BITWIDTH-1:0] d_out;
  logic                           d_valid;
  logic                           d_ready;

  modport master (
    output P,
    output p_valid,
    output d_ready,
    input  p_ready,
    input  d_out,
    input  d_valid
  );

  modport slave (
    input  P,
    input  p_valid,
    input  d_ready,
    output p_ready,
    output d_out,
    output d_valid
  );
endinterface

// File: rtl/idct_dot_acc.sv
// IDCT dot-product accumulator.
// Sums N_TAPS signed products into one term, rounds (half up), arithmetically
// shifts right by SHIFT, saturates to OUT_BITWIDTH and offers the term on a
// valid/ready output. A held, unconsumed term back-pressures the product
// source. Terms are counted modulo 64 so the end of an 8x8 block is flagged.
// Ports:
//   clk        : clock, all state on posedge
//   rstP       : synchronous active-high reset
//   bus        : product input stream and term output stream (slave side)
//   tap_cnt    : products accumulated in the current term
//   out_idx    : index of the term currently / next offered (0..63)
//   block_done : one-cycle pulse after term 63 is consumed
//   sat_flag   : sticky saturation indicator
//   clr_sat    : clears sat_flag (a same-cycle saturation wins)
module idct_dot_acc #(
  parameter int unsigned P_BITWIDTH   = 32,
  parameter int unsigned N_TAPS       = 8,
  parameter int unsigned ACC_BITWIDTH = 35,
  parameter int unsigned SHIFT        = 8,
  parameter int unsigned OUT_BITWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rstP,
  idct_dot_acc_if.slave              bus,
  output logic [$clog2(N_TAPS)-1:0]  tap_cnt,
  output logic [5:0]                 out_idx,
  output logic                       block_done,
  output logic                       sat_flag,
  input  logic                       clr_sat
);

  localparam int unsigned TapBits = $clog2(N_TAPS);
  // One guard bit above the accumulator so the rounding add cannot wrap.
  localparam int unsigned W       = ACC_BITWIDTH + 1;

  localparam logic signed [W-1:0] RoundK = W'(2 ** (SHIFT - 1));
  localparam logic signed [W-1:0] OutMax =
      {{(W - OUT_BITWIDTH + 1){1'b0}}, {(OUT_BITWIDTH - 1){1'b1}}};
  localparam logic signed [W-1:0] OutMin =
      {{(W - OUT_BITWIDTH + 1){1'b1}}, {(OUT_BITWIDTH - 1){1'b0}}};
  localparam logic [TapBits-1:0]  LastTap = TapBits'(N_TAPS - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e state_q, state_d;

  logic signed [ACC_BITWIDTH-1:0] acc_q, acc_d;
  logic [TapBits-1:0]             tap_q, tap_d;
  logic signed [OUT_BITWIDTH-1:0] d_out_q, d_out_d;
  logic                           d_valid_q, d_valid_d;
  logic [5:0]                     out_idx_q, out_idx_d;
  logic                           block_done_q, block_done_d;
  logic                           sat_q, sat_d;

  logic                           p_ready;
  logic                           accept;
  logic                           handshake;
  logic                           final_tap;

  logic signed [ACC_BITWIDTH-1:0] p_sext;
  logic signed [W-1:0]            sum;
  logic signed [W-1:0]            rounded;
  logic signed [W-1:0]            r;
  logic                           sat_hi;
  logic                           sat_lo;
  logic signed [OUT_BITWIDTH-1:0] term;

  // Handshake decode
  assign p_ready   = ~d_valid_q | bus.d_ready;
  assign accept    = bus.p_valid & p_ready;
  assign handshake = d_valid_q & bus.d_ready;
  assign final_tap = accept & (state_q == StAcc) & (tap_q == LastTap);

  // Term arithmetic on the final product, in W bits
  assign p_sext  = {{(ACC_BITWIDTH - P_BITWIDTH){bus.P[P_BITWIDTH-1]}}, bus.P};
  assign sum     = {acc_q[ACC_BITWIDTH-1], acc_q} + {p_sext[ACC_BITWIDTH-1], p_sext};
  assign rounded = sum + RoundK;
  assign r       = rounded >>> SHIFT;
  assign sat_hi  = (r > OutMax);
  assign sat_lo  = (r < OutMin);

  always_comb begin
    term = r[OUT_BITWIDTH-1:0];
    if (sat_hi) begin
      term = OutMax[OUT_BITWIDTH-1:0];
    end else if (sat_lo) begin
      term = OutMin[OUT_BITWIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rstP) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      tap_q        <= '0;
      d_out_q      <= '0;
      d_valid_q    <= 1'b0;
      out_idx_q    <= '0;
      block_done_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tap_q        <= tap_d;
      d_out_q      <= d_out_d;
      d_valid_q    <= d_valid_d;
      out_idx_q    <= out_idx_d;
      block_done_q <= block_done_d;
      sat_q        <= sat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StAcc;
      StAcc:  if (final_tap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output-register next values
  always_comb begin
    acc_d        = acc_q;
    tap_d        = tap_q;
    d_out_d      = d_out_q;
    d_valid_d    = d_valid_q;
    out_idx_d    = out_idx_q;
    block_done_d = 1'b0;
    sat_d        = sat_q;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          acc_d = p_sext;
          tap_d = TapBits'(1);
        end
        StAcc: begin
          if (tap_q == LastTap) begin
            tap_d = '0;
          end else begin
            acc_d = acc_q + p_sext;
            tap_d = tap_q + TapBits'(1);
          end
        end
        default: begin
          tap_d = '0;
        end
      endcase
    end

    if (handshake) begin
      d_valid_d    = 1'b0;
      out_idx_d    = out_idx_q + 6'd1;
      block_done_d = (out_idx_q == 6'd63);
    end

    // A new term overrides the handshake clear, giving a bubble-free hand-off.
    if (final_tap) begin
      d_out_d   = term;
      d_valid_d = 1'b1;
    end

    if (final_tap && (sat_hi || sat_lo)) begin
      sat_d = 1'b1;
    end else if (clr_sat) begin
      sat_d = 1'b0;
    end
  end

  assign bus.p_ready  = p_ready;
  assign bus.d_out    = d_out_q;
  assign bus.d_valid  = d_valid_q;
  assign tap_cnt      = tap_q;
  assign out_idx      = out_idx_q;
  assign block_done   = block_done_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_idct_dot_acc.sv
module tb_idct_dot_acc;

  localparam int Timeout = 50;

  logic       clk = 1'b0;
  logic       rstP;
  logic [2:0] tap_cnt;
  logic [5:0] out_idx;
  logic       block_done;
  logic       sat_flag;
  logic       clr_sat;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  idct_dot_acc_if #(.P_BITWIDTH(32), .OUT_BITWIDTH(16)) bus ();

  idct_dot_acc #(
    .P_BITWIDTH  (32),
    .N_TAPS      (8),
    .ACC_BITWIDTH(35),
    .SHIFT       (8),
    .OUT_BITWIDTH(16)
  ) dut (
    .clk       (clk),
    .rstP      (rstP),
    .bus       (bus),
    .tap_cnt   (tap_cnt),
    .out_idx   (out_idx),
    .block_done(block_done),
    .sat_flag  (sat_flag),
    .clr_sat   (clr_sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (block_done) done_pulses++;
  end

  typedef struct {
    logic signed [31:0] first;
    logic signed [31:0] rest;
    logic signed [15:0] exp_dout;
    logic               exp_sat;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one product and wait (bounded) for it to be accepted.
  task automatic push(input logic signed [31:0] val);
    int n;
    bus.P = val;
    bus.p_valid = 1'b1;
    n = 0;
    while (!bus.p_ready && n < Timeout) begin
      tick();
      n++;
    end
    if (n >= Timeout) check("push_timeout", 0, 1);
    tick();
    bus.p_valid = 1'b0;
  endtask

  task automatic push_term(input logic signed [31:0] first, input logic signed [31:0] rest);
    push(first);
    for (int i = 1; i < 8; i++) push(rest);
  endtask

  task automatic do_reset();
    rstP = 1'b1;
    tick();
    rstP = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'sd256, 32'sd256, 16'sd8, 1'b0};
    vecs[1] = '{32'sd384, 32'sd0, 16'sd2, 1'b0};
    vecs[2] = '{-32'sd384, 32'sd0, -16'sd1, 1'b0};
    vecs[3] = '{32'sd127, 32'sd0, 16'sd0, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 16'sd32767, 1'b1};
    vecs[5] = '{32'h80000000, 32'h80000000, -16'sd32768, 1'b1};

    rstP = 1'b1;
    bus.P = '0;
    bus.p_valid = 1'b0;
    bus.d_ready = 1'b1;
    clr_sat = 1'b0;
    tick();
    tick();
    check("rst_d_valid", bus.d_valid, 0);
    check("rst_d_out", bus.d_out, 0);
    check("rst_tap_cnt", tap_cnt, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_block_done", block_done, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_p_ready", bus.p_ready, 1);
    rstP = 1'b0;
    tick();

    // Table-driven terms, d_ready held high
    for (int v = 0; v < 6; v++) begin
      push_term(vecs[v].first, vecs[v].rest);
      check($sformatf("vec%0d_d_valid", v), bus.d_valid, 1);
      check($sformatf("vec%0d_d_out", v), bus.d_out, vecs[v].exp_dout);
      check($sformatf("vec%0d_tap_cnt", v), tap_cnt, 0);
      check($sformatf("vec%0d_sat", v), sat_flag, vecs[v].exp_sat);
      tick();
      check($sformatf("vec%0d_d_valid_drop", v), bus.d_valid, 0);
    end

    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    check("clr_sat", sat_flag, 0);

    // Back-pressure
    do_reset();
    bus.d_ready = 1'b0;
    push_term(32'sd256, 32'sd256);
    check("bp_first_valid", bus.d_valid, 1);
    check("bp_first_dout", bus.d_out, 8);
    bus.P = 32'sd512;
    bus.p_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("bp_p_ready_low", bus.p_ready, 0);
    check("bp_dout_held", bus.d_out, 8);
    check("bp_valid_held", bus.d_valid, 1);
    check("bp_no_accept", tap_cnt, 0);
    bus.d_ready = 1'b1;
    #1;
    check("bp_p_ready_high", bus.p_ready, 1);
    tick();
    check("bp_tap_after_release", tap_cnt, 1);
    check("bp_out_idx", out_idx, 1);
    for (int i = 1; i < 8; i++) push(32'sd512);
    check("bp_second_valid", bus.d_valid, 1);
    check("bp_second_dout", bus.d_out, 16);
    tick();

    // Block count: 64 terms with d_ready high
    do_reset();
    bus.d_ready = 1'b1;
    begin
      int base;
      base = done_pulses;
      for (int t = 0; t < 64; t++) begin
        push_term(32'sd256, 32'sd256);
        check($sformatf("blk_out_idx%0d", t), out_idx, t);
      end
      tick();
      check("blk_wrap", out_idx, 0);
      check("blk_done_pulse", block_done, 1);
      tick();
      check("blk_done_clear", block_done, 0);
      check("blk_done_count", done_pulses - base, 1);
    end

    // Reset mid-operation: partial sum discarded, index cleared
    do_reset();
    push_term(32'sd256, 32'sd256);
    for (int i = 0; i < 3; i++) push(32'sd1000);
    check("mid_tap3", tap_cnt, 3);
    check("mid_idx1", out_idx, 1);
    rstP = 1'b1;
    tick();
    rstP = 1'b0;
    check("mid_rst_tap", tap_cnt, 0);
    check("mid_rst_valid", bus.d_valid, 0);
    check("mid_rst_idx", out_idx, 0);
    bus.d_ready = 1'b0;
    push_term(32'sd256, 32'sd256);
    check("mid_held_valid", bus.d_valid, 1);
    rstP = 1'b1;
    tick();
    rstP = 1'b0;
    check("mid_rst_held_valid", bus.d_valid, 0);
    check("mid_rst_held_dout", bus.d_out, 0);
    bus.d_ready = 1'b1;
    push_term(32'sd512, 32'sd512);
    check("post_rst_valid", bus.d_valid, 1);
    check("post_rst_dout", bus.d_out, 16);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
